// File: rtl/led_pattern_gen.sv
// LED pattern generator: CHANNELS independent LED outputs, each OFF, ON, BLINK or PWM.
// A prescaler divides ice_clk_i into phase ticks. A PWM_W-bit phase counter advances on
// each tick, and a full phase wrap defines one PWM period. Configuration writes land in
// per-channel pending registers and are promoted to active registers only at a period
// boundary, so LED patterns never change mid-period.
//
// Ports:
//   ice_clk_i       single clock, rising edge
//   rst_ni          asynchronous active-low reset
//   cfg_we_i        config write strobe, sampled every cycle
//   cfg_ch_i        target channel index
//   cfg_mode_i      0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_val_i       PWM duty or blink interval (in periods, minus one)
//   cfg_ack_o       one-cycle pulse after an accepted write
//   cfg_err_o       one-cycle pulse after a write to a non-existent channel
//   led_o           registered LED drive, bit i = channel i, active-high
//   period_start_o  one-cycle pulse in the cycle after a boundary tick
module led_pattern_gen #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned PRESC    = 16,
  localparam int unsigned ChW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                ice_clk_i,
  input  logic                rst_ni,
  input  logic                cfg_we_i,
  input  logic [ChW-1:0]      cfg_ch_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [PWM_W-1:0]    cfg_val_i,
  output logic                cfg_ack_o,
  output logic                cfg_err_o,
  output logic [CHANNELS-1:0] led_o,
  output logic                period_start_o
);

  localparam int unsigned PrescW = $clog2(PRESC);

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModePwm   = 2'd3
  } mode_e;

  logic [PrescW-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]  phase_q, phase_d;
  logic              tick;
  logic              boundary;
  logic              ch_valid;

  mode_e [CHANNELS-1:0]           mode_pend_q, mode_pend_d;
  mode_e [CHANNELS-1:0]           mode_act_q, mode_act_d;
  logic  [CHANNELS-1:0][PWM_W-1:0] val_pend_q, val_pend_d;
  logic  [CHANNELS-1:0][PWM_W-1:0] val_act_q, val_act_d;
  logic  [CHANNELS-1:0][PWM_W-1:0] blink_cnt_q, blink_cnt_d;
  logic  [CHANNELS-1:0]           blink_led_q, blink_led_d;

  logic [CHANNELS-1:0] led_q, led_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                ps_q, ps_d;

  // Timebase: prescaler, phase counter and boundary detection.
  always_comb begin
    tick     = (presc_q == PrescW'(PRESC - 1));
    presc_d  = tick ? '0 : presc_q + PrescW'(1);
    phase_d  = tick ? phase_q + PWM_W'(1) : phase_q;
    boundary = tick && (phase_q == '1);
    ps_d     = boundary;
  end

  // Config write decode.
  always_comb begin
    ch_valid = (32'(cfg_ch_i) < CHANNELS);
    ack_d    = cfg_we_i && ch_valid;
    err_d    = cfg_we_i && !ch_valid;
  end

  // Per-channel pending/active registers, blink state and LED next-state.
  always_comb begin
    mode_pend_d = mode_pend_q;
    val_pend_d  = val_pend_q;
    mode_act_d  = mode_act_q;
    val_act_d   = val_act_q;
    blink_cnt_d = blink_cnt_q;
    blink_led_d = blink_led_q;
    led_d       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Boundary promotion reads the pre-write pending value, so a write coinciding
      // with a boundary tick only takes effect at the following boundary.
      if (boundary) begin
        mode_act_d[i] = mode_pend_q[i];
        val_act_d[i]  = val_pend_q[i];
        if (mode_pend_q[i] != ModeBlink || mode_act_q[i] != ModeBlink) begin
          // Not blinking, or just entering BLINK: restart from LED off.
          blink_cnt_d[i] = '0;
          blink_led_d[i] = 1'b0;
        end else if (blink_cnt_q[i] == val_act_q[i]) begin
          blink_cnt_d[i] = '0;
          blink_led_d[i] = ~blink_led_q[i];
        end else begin
          blink_cnt_d[i] = blink_cnt_q[i] + PWM_W'(1);
        end
      end

      if (ack_d && (cfg_ch_i == ChW'(i))) begin
        mode_pend_d[i] = mode_e'(cfg_mode_i);
        val_pend_d[i]  = cfg_val_i;
      end

      unique case (mode_act_q[i])
        ModeOff:   led_d[i] = 1'b0;
        ModeOn:    led_d[i] = 1'b1;
        ModeBlink: led_d[i] = blink_led_q[i];
        ModePwm:   led_d[i] = (phase_q < val_act_q[i]);
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ice_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      phase_q     <= '0;
      mode_pend_q <= {CHANNELS{ModeOff}};
      mode_act_q  <= {CHANNELS{ModeOff}};
      val_pend_q  <= '0;
      val_act_q   <= '0;
      blink_cnt_q <= '0;
      blink_led_q <= '0;
      led_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      mode_pend_q <= mode_pend_d;
      mode_act_q  <= mode_act_d;
      val_pend_q  <= val_pend_d;
      val_act_q   <= val_act_d;
      blink_cnt_q <= blink_cnt_d;
      blink_led_q <= blink_led_d;
      led_q       <= led_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      ps_q        <= ps_d;
    end
  end

  assign led_o          = led_q;
  assign cfg_ack_o      = ack_q;
  assign cfg_err_o      = err_q;
  assign period_start_o = ps_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (CHANNELS=3, PWM_W=4, PRESC=4, 64-cycle period).
// A reference model computes expected outputs from cycle arithmetic and pushes them into
// queues; a separate monitor pops and compares on every falling edge.
module tb_led_pattern_gen;

  localparam int unsigned CHANNELS = 3;
  localparam int unsigned PWM_W    = 4;
  localparam int unsigned PRESC    = 4;
  localparam int NPH    = 16;
  localparam int PERIOD = 64;

  localparam int MOff   = 0;
  localparam int MOn    = 1;
  localparam int MBlink = 2;
  localparam int MPwm   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_val = '0;
  logic       cfg_ack;
  logic       cfg_err;
  logic [2:0] led;
  logic       period_start;

  led_pattern_gen #(
    .CHANNELS(CHANNELS),
    .PWM_W   (PWM_W),
    .PRESC   (PRESC)
  ) dut (
    .ice_clk_i     (clk),
    .rst_ni        (rst_n),
    .cfg_we_i      (cfg_we),
    .cfg_ch_i      (cfg_ch),
    .cfg_mode_i    (cfg_mode),
    .cfg_val_i     (cfg_val),
    .cfg_ack_o     (cfg_ack),
    .cfg_err_o     (cfg_err),
    .led_o         (led),
    .period_start_o(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] led;
    logic       ps;
  } out_t;

  typedef struct {
    int   due;
    logic ack;
    logic err;
  } resp_t;

  out_t  out_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;  // index of the current cycle since reset release

  int pend_mode[CHANNELS];
  int pend_val[CHANNELS];
  int act_mode[CHANNELS];
  int act_val[CHANNELS];
  int entry[CHANNELS];  // boundaries passed when the channel entered BLINK

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: runs on rising edges, predicts outputs of the next cycle.
  initial begin
    int   c, phase, passed, k;
    bit   bnd;
    out_t o;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < CHANNELS; i++) begin
          pend_mode[i] = MOff; pend_val[i] = 0;
          act_mode[i]  = MOff; act_val[i]  = 0;
          entry[i]     = 0;
        end
        cyc = 0;
        out_q.delete();
        resp_q.delete();
      end else begin
        c      = cyc;
        phase  = (c / PRESC) % NPH;
        bnd    = ((c % PERIOD) == PERIOD - 1);
        passed = c / PERIOD;
        o.ps   = bnd;
        for (int i = 0; i < CHANNELS; i++) begin
          case (act_mode[i])
            MOn:    o.led[i] = 1'b1;
            MPwm:   o.led[i] = (phase < act_val[i]);
            MBlink: begin
              k = passed - entry[i];
              o.led[i] = (((k / (act_val[i] + 1)) % 2) == 1);
            end
            default: o.led[i] = 1'b0;
          endcase
        end
        out_q.push_back(o);
        if (bnd) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (pend_mode[i] == MBlink && act_mode[i] != MBlink) entry[i] = passed + 1;
            act_mode[i] = pend_mode[i];
            act_val[i]  = pend_val[i];
          end
        end
        if (cfg_we) begin
          if (int'(cfg_ch) < CHANNELS) begin
            pend_mode[cfg_ch] = int'(cfg_mode);
            pend_val[cfg_ch]  = int'(cfg_val);
            resp_q.push_back('{due: c + 1, ack: 1'b1, err: 1'b0});
          end else begin
            resp_q.push_back('{due: c + 1, ack: 1'b0, err: 1'b1});
          end
        end
        cyc = c + 1;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on falling edges.
  initial begin
    out_t  o;
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_q.delete();
        resp_q.delete();
        check("reset_outputs", {led, cfg_ack, cfg_err, period_start}, 0);
      end else begin
        if (out_q.size() > 0) begin
          o = out_q.pop_front();
          check("led", int'(led), int'(o.led));
          check("period_start", int'(period_start), int'(o.ps));
        end
        if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
          r = resp_q.pop_front();
          check("cfg_ack_err", int'({cfg_ack, cfg_err}), int'({r.ack, r.err}));
        end else begin
          check("no_spurious_ack_err", int'({cfg_ack, cfg_err}), 0);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issued 1 time unit after a rising edge; sampled at the next rising edge.
  task automatic cfg_write(input int ch, input int mode, input int val);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_mode = 2'(mode);
    cfg_val  = 4'(val);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_period_pos(input int pos);
    for (int k = 0; k < PERIOD && (cyc % PERIOD) != pos; k++) wait_cycles(1);
    check("reached_period_pos", cyc % PERIOD, pos);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #(-1 + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ch, mode, val;
    do_reset();

    // Idle: LEDs stay off, period_start every 64 cycles.
    wait_cycles(140);

    // PWM on ch0, BLINK on ch1, invalid ch3.
    cfg_write(0, MPwm, 4);
    wait_cycles(5);
    cfg_write(1, MBlink, 2);
    wait_cycles(3);
    cfg_write(3, MOn, 7);
    wait_cycles(2);

    // ON for ch2 written exactly on a boundary tick.
    wait_period_pos(PERIOD - 1);
    cfg_write(2, MOn, 0);
    wait_cycles(7 * PERIOD);

    // Randomised writes, including back-to-back and invalid channels.
    for (int n = 0; n < 150; n++) begin
      ch   = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 3));
      val  = int'($urandom_range(0, 15));
      if (mode == MBlink) val = (ch + 1) % 16;  // one blink interval per channel
      cfg_write(ch, mode, val);
      if ($urandom_range(0, 3) != 0) wait_cycles(int'($urandom_range(0, 40)));
    end
    wait_cycles(2 * PERIOD);

    // Mid-period reset with ch0 in PWM, while a write is in flight.
    cfg_write(0, MPwm, 4);
    wait_cycles(2 * PERIOD);
    wait_period_pos(5);
    check("led0_high_before_reset", int'(led[0]), 1);
    cfg_we   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_mode = 2'(MOn);
    cfg_val  = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", int'(led), 0);
    check("async_reset_flags", int'({cfg_ack, cfg_err, period_start}), 0);
    cfg_we = 1'b0;
    wait_cycles(3);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_cycles(3 * PERIOD);

    wait_cycles(4);
    check("resp_queue_drained", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
